multi_clock_source: RTL and testbench
=====================================

// Module: multi_clock_source
// PURPOSE
//  Synthesizable multi-channel clock generator for FPGA-hosted simulation.
//  Derives NUM_CLOCKS divided clocks from one host clock. Each channel has a
//  runtime-programmable period, high time and initial level, and is enabled per
//  channel. Reconfiguration is glitch-free. Feeds clock bridges / target-clock
//  domains in place of fixed behavioural reference sources.
// PARAMETERS
//  NUM_CLOCKS     4       number of output channels (1..16)
//  CNT_WIDTH      16      period/high-time counter width
//  DEFAULT_PERIOD 2       reset period for every channel (host cycles, >=2)
//  DEFAULT_HIGH   1       reset high time (1..DEFAULT_PERIOD-1)
//  DEFAULT_INIT   '0      NUM_CLOCKS-bit reset level / first-phase select
//  DEFAULT_ENABLE '1      NUM_CLOCKS-bit reset enable
// PORTS
//  clock         in   1                     host clock
//  reset         in   1                     async, active-high
//  cfg_valid     in   1                     config write request
//  cfg_ready     out  1                     config write accept
//  cfg_chan      in   $clog2(NUM_CLOCKS)    target channel
//  cfg_period    in   CNT_WIDTH             new period
//  cfg_high      in   CNT_WIDTH             new high time
//  cfg_init      in   1                     new initial level
//  cfg_enable    in   1                     new enable
//  cfg_err       out  1                     1-cycle pulse: write rejected
//  clock_out     out  NUM_CLOCKS            generated clocks, each directly from a flop
//  period_start  out  NUM_CLOCKS            1-cycle pulse, first host cycle of a period
//  pending       out  NUM_CLOCKS            shadow config waiting to apply
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream): cnt=0; active cfg=DEFAULTs;
//    pending=0; clock_out[i]=DEFAULT_INIT[i]; period_start=0; cfg_err=0.
//  - Per channel, active {P,H,I,E}. When E=1, cnt counts 0..P-1 and wraps to 0.
//    Level: I=1 -> high for cnt<H, else low. I=0 -> low for cnt<P-H, else high.
//    Hence a period starts in level I, which matches the prior fixed-source semantics.
//  - clock_out[i] is registered from next-state cnt/cfg. It changes only at
//    phase boundaries. No combinational path to the output.
//  - period_start[i]=1 in every cycle where a running channel has registered cnt==0.
//  - E=0: cnt held 0; clock_out[i]=I; period_start=0.
//  - Handshake: cfg_ready = !pending[cfg_chan]. Transfer occurs when valid&&ready.
//    Requestor holds all fields stable while valid&&!ready.
//  - Validation on transfer: reject if cfg_period<2, cfg_high==0 or cfg_high>=cfg_period.
//    Reject -> cfg_err pulses the next cycle; no state change. Else the shadow is
//    loaded and pending[chan]=1 the next cycle.
//  - Apply (glitch-free):
//      * running channel: applies in the cycle where cnt==P-1 && pending. Next cycle
//        cnt=0 and the new level is used.
//      * disabled channel: applies in the first cycle pending=1.
//    Apply clears pending in the same edge.
//  - Disable request: still applied at the wrap, so the final period completes in full.
//  - Simultaneous accept and wrap on the same channel: the accept lands in the shadow.
//    It applies at the following wrap, never at the current one.
//  - Writes to different channels are independent. At most one write per cycle.
//  - Reset mid-period or mid-pending: all state returns to reset values immediately.
//    The pending update is discarded.
//  - Widths: cnt is compared unsigned at CNT_WIDTH. P-H is computed at CNT_WIDTH
//    and is always >0 for valid cfg.
// STRUCTURE
//  - Package multi_clock_source_pkg: typedef struct packed {period, high, init, enable}
//    chan_cfg_t; localparam CHAN_W; function cfg_valid_f(chan_cfg_t) used for validation.
//  - Sub-module clock_source_channel: counter, active and shadow cfg, pending, output flop.
//    The top instantiates NUM_CLOCKS copies and holds the shared handshake/validation/error logic.
// TESTING
//  1 Reset defaults, NUM_CLOCKS=4, P=2 H=1 I=0 -> every clock_out toggles each cycle,
//    starts low; period_start every 2 cycles.
//  2 Write ch1 P=5 H=2 I=1 -> after the current wrap: high 2, low 3, repeating;
//    pending[1] is 1 until the apply cycle.
//  3 Write ch2 P=4 H=4, then P=1 H=0 -> cfg_err pulses twice; ch2 waveform unchanged.
//  4 Second write to ch1 while pending[1]=1 -> cfg_ready=0 with cfg_chan=1 and =1 with
//    cfg_chan=0; the ch0 write is accepted in parallel.
//  5 Accept on the exact cnt==P-1 cycle -> old period repeats once; new cfg applies at
//    the next wrap.
//  6 Disable ch3 mid-period -> period finishes; clock_out[3] then holds I. Re-enable ->
//    applies next cycle, period_start asserts. Assert reset mid-pending -> defaults,
//    pending=0.

Source files
------------

// File: rtl/multi_clock_source_pkg.sv
// Shared types and helpers for the multi-channel clock generator.
// CNT_WIDTH on the top must equal CNT_W here; the config struct is fixed-width.
package multi_clock_source_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CHAN_W = 4;
    localparam int unsigned CFG_W  = 2 * CNT_W + 2;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             init;
        logic             enable;
    } chan_cfg_t;

    function automatic logic cfg_valid_f(chan_cfg_t c);
        return (c.period >= CNT_W'(2)) && (c.high != '0) && (c.high < c.period);
    endfunction

    // A period always starts in the init level, then flips once.
    function automatic logic level_f(logic [CNT_W-1:0] cnt, chan_cfg_t c);
        logic [CNT_W-1:0] low_len;
        low_len = c.period - c.high;
        if (!c.enable) begin
            return c.init;
        end else if (c.init) begin
            return cnt < c.high;
        end else begin
            return !(cnt < low_len);
        end
    endfunction

endpackage

// File: rtl/multi_clock_source_channel.sv
// One generated clock: counter, active/shadow config, pending flag and output flop.
// Shadow config is only swapped in at a period boundary or while disabled.
module clock_source_channel
    import multi_clock_source_pkg::*;
#(
    parameter logic [CFG_W-1:0] RESET_CFG = {16'd2, 16'd1, 1'b0, 1'b1}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CFG_W-1:0] load_cfg_i,
    output logic             clock_o,
    output logic             period_start_o,
    output logic             pending_o
);

    localparam chan_cfg_t RstCfg = RESET_CFG;

    chan_cfg_t        act_q, act_d, shd_q, shd_d, load_cfg;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             ps_q, ps_d;
    logic             wrap;

    assign load_cfg = load_cfg_i;
    assign wrap     = (cnt_q == (act_q.period - CNT_W'(1)));

    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (pend_q && (!act_q.enable || wrap)) begin
            act_d  = shd_q;
            pend_d = 1'b0;
            cnt_d  = '0;
        end else if (act_q.enable) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        // The top only loads while not pending, so this never collides with an apply.
        if (load_i) begin
            shd_d  = load_cfg;
            pend_d = 1'b1;
        end
        clk_d = level_f(cnt_d, act_d);
        ps_d  = act_d.enable && (cnt_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_q  <= RstCfg;
            shd_q  <= RstCfg;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            clk_q  <= RstCfg.init;
            ps_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            ps_q   <= ps_d;
        end
    end

    assign clock_o        = clk_q;
    assign period_start_o = ps_q;
    assign pending_o      = pend_q;

endmodule

// File: rtl/multi_clock_source.sv
// Multi-channel programmable clock generator: shared config handshake and
// validation in front of NUM_CLOCKS independent channel instances.
module multi_clock_source
    import multi_clock_source_pkg::*;
#(
    parameter int unsigned            NUM_CLOCKS     = 4,
    parameter int unsigned            CNT_WIDTH      = CNT_W,
    parameter int unsigned            DEFAULT_PERIOD = 2,
    parameter int unsigned            DEFAULT_HIGH   = 1,
    parameter logic [NUM_CLOCKS-1:0]  DEFAULT_INIT   = '0,
    parameter logic [NUM_CLOCKS-1:0]  DEFAULT_ENABLE = '1,
    localparam int unsigned           ChanW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ChanW-1:0]      cfg_chan,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic [CNT_WIDTH-1:0]  cfg_high,
    input  logic                  cfg_init,
    input  logic                  cfg_enable,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] clock_out,
    output logic [NUM_CLOCKS-1:0] period_start,
    output logic [NUM_CLOCKS-1:0] pending
);

    chan_cfg_t             new_cfg;
    logic                  chan_ok, sel_pend, fire, accept;
    logic [NUM_CLOCKS-1:0] load;
    logic                  err_q, err_d;

    always_comb begin
        new_cfg.period = cfg_period;
        new_cfg.high   = cfg_high;
        new_cfg.init   = cfg_init;
        new_cfg.enable = cfg_enable;
    end

    // An out-of-range channel is accepted and then rejected so it cannot stall the requestor.
    always_comb begin
        chan_ok  = 1'b0;
        sel_pend = 1'b0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == ChanW'(i)) begin
                chan_ok  = 1'b1;
                sel_pend = pending[i];
            end
        end
    end

    assign cfg_ready = !sel_pend;
    assign fire      = cfg_valid && cfg_ready;
    assign accept    = fire && chan_ok && cfg_valid_f(new_cfg);
    assign err_d     = fire && !accept;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            load[i] = accept && (cfg_chan == ChanW'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        localparam logic [CFG_W-1:0] RstCfg = {CNT_W'(DEFAULT_PERIOD), CNT_W'(DEFAULT_HIGH),
                                               DEFAULT_INIT[g], DEFAULT_ENABLE[g]};
        clock_source_channel #(
            .RESET_CFG(RstCfg)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .load_i        (load[g]),
            .load_cfg_i    (new_cfg),
            .clock_o       (clock_out[g]),
            .period_start_o(period_start[g]),
            .pending_o     (pending[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_source.sv
// Directed bench for multi_clock_source; all checks sampled on the falling edge.
module tb_multi_clock_source;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        cfg_init;
    logic        cfg_enable;
    logic        cfg_err;
    logic [3:0]  clock_out;
    logic [3:0]  period_start;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    multi_clock_source dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_init    (cfg_init),
        .cfg_enable  (cfg_enable),
        .cfg_err     (cfg_err),
        .clock_out   (clock_out),
        .period_start(period_start),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wr(input logic [1:0] ch, input int p, input int h, input logic i,
                      input logic e);
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        cfg_init   = i;
        cfg_enable = e;
        #1;
    endtask

    logic [5:0] exp_clk1;
    logic [5:0] exp_ps1;

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_init   = 1'b0;
        cfg_enable = 1'b0;
        tick();
        tick();
        chk("rst_clk", 32'(clock_out), 32'h0);
        chk("rst_ps", 32'(period_start), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);
        reset = 1'b0;

        // Defaults: every channel toggles each host cycle, period_start on even cycles.
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("dflt_clk", 32'(clock_out), (k % 2 == 1) ? 32'hF : 32'h0);
            chk("dflt_ps", 32'(period_start), (k % 2 == 1) ? 32'h0 : 32'hF);
        end

        // ch1 -> P=5 H=2 I=1, applied at the current wrap.
        wr(2'd1, 5, 2, 1'b1, 1'b1);
        chk("t2_ready", 32'(cfg_ready), 32'h1);
        tick();
        chk("t2_pend", 32'(pending), 32'h2);
        chk("t2_oldclk1", 32'(clock_out[1]), 32'h1);
        cfg_valid = 1'b0;
        exp_clk1 = 6'b100011;
        exp_ps1  = 6'b100001;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("t2_clk1", 32'(clock_out[1]), 32'(exp_clk1[j]));
            chk("t2_ps1", 32'(period_start[1]), 32'(exp_ps1[j]));
            if (j == 0) chk("t2_pend_clr", 32'(pending), 32'h0);
        end

        // Invalid writes to ch2 are rejected with a one-cycle error pulse each.
        wr(2'd2, 4, 4, 1'b0, 1'b1);
        chk("t3_ready", 32'(cfg_ready), 32'h1);
        tick();
        chk("t3_err1", 32'(cfg_err), 32'h1);
        chk("t3_pend1", 32'(pending), 32'h0);
        wr(2'd2, 1, 0, 1'b0, 1'b1);
        tick();
        chk("t3_err2", 32'(cfg_err), 32'h1);
        cfg_valid = 1'b0;
        tick();
        chk("t3_err_clr", 32'(cfg_err), 32'h0);
        chk("t3_clk2", 32'(clock_out[2]), 32'h0);

        // Busy ch1 back-pressures while ch0 is accepted.
        wr(2'd1, 3, 1, 1'b0, 1'b1);
        chk("t4_ready_a", 32'(cfg_ready), 32'h1);
        tick();
        chk("t4_ready_busy", 32'(cfg_ready), 32'h0);
        wr(2'd0, 4, 1, 1'b1, 1'b1);
        chk("t4_ready_ch0", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        chk("t4_pend_a", 32'(pending), 32'h1);
        chk("t4_clk1_new", 32'(clock_out[1]), 32'h0);
        chk("t4_ps1_new", 32'(period_start[1]), 32'h1);
        tick();
        chk("t4_pend_b", 32'(pending), 32'h1);
        chk("t4_clk0_old", 32'(clock_out[0]), 32'h1);
        tick();
        chk("t4_pend_c", 32'(pending), 32'h0);
        chk("t4_clk0_new", 32'(clock_out[0]), 32'h1);
        chk("t4_ps0_new", 32'(period_start[0]), 32'h1);
        tick();
        chk("t4_clk0_a", 32'(clock_out[0]), 32'h0);
        chk("t4_clk1_a", 32'(clock_out[1]), 32'h0);
        chk("t4_ps1_a", 32'(period_start[1]), 32'h1);
        tick();
        chk("t4_clk1_b", 32'(clock_out[1]), 32'h0);
        tick();
        chk("t4_clk1_c", 32'(clock_out[1]), 32'h1);
        chk("t4_clk0_c", 32'(clock_out[0]), 32'h0);

        // Accept lands on ch1's cnt==P-1 cycle: old period repeats once more.
        wr(2'd1, 2, 1, 1'b1, 1'b1);
        chk("t5_ready", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        chk("t5_pend_a", 32'(pending), 32'h2);
        chk("t5_clk1_a", 32'(clock_out[1]), 32'h0);
        chk("t5_ps1_a", 32'(period_start[1]), 32'h1);
        chk("t5_clk0_a", 32'(clock_out[0]), 32'h1);
        tick();
        chk("t5_clk1_b", 32'(clock_out[1]), 32'h0);
        chk("t5_pend_b", 32'(pending), 32'h2);
        tick();
        chk("t5_clk1_c", 32'(clock_out[1]), 32'h1);
        chk("t5_pend_c", 32'(pending), 32'h2);
        tick();
        chk("t5_clk1_d", 32'(clock_out[1]), 32'h1);
        chk("t5_ps1_d", 32'(period_start[1]), 32'h1);
        chk("t5_pend_d", 32'(pending), 32'h0);
        tick();
        chk("t5_clk1_e", 32'(clock_out[1]), 32'h0);

        // Disable ch3 mid-period; the running period completes first.
        wr(2'd3, 2, 1, 1'b0, 1'b0);
        tick();
        cfg_valid = 1'b0;
        chk("t6_clk3_a", 32'(clock_out[3]), 32'h1);
        chk("t6_pend_a", 32'(pending), 32'h8);
        tick();
        chk("t6_clk3_b", 32'(clock_out[3]), 32'h0);
        chk("t6_pend_b", 32'(pending), 32'h0);
        chk("t6_ps3_b", 32'(period_start[3]), 32'h0);
        tick();
        chk("t6_clk3_c", 32'(clock_out[3]), 32'h0);
        chk("t6_ps3_c", 32'(period_start[3]), 32'h0);
        tick();
        chk("t6_clk3_d", 32'(clock_out[3]), 32'h0);

        // Re-enable ch3: applies on the first pending cycle.
        wr(2'd3, 3, 1, 1'b1, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk("t6_pend_e", 32'(pending), 32'h8);
        chk("t6_clk3_e", 32'(clock_out[3]), 32'h0);
        tick();
        chk("t6_pend_f", 32'(pending), 32'h0);
        chk("t6_clk3_f", 32'(clock_out[3]), 32'h1);
        chk("t6_ps3_f", 32'(period_start[3]), 32'h1);
        tick();
        chk("t6_clk3_g", 32'(clock_out[3]), 32'h0);
        chk("t6_ps3_g", 32'(period_start[3]), 32'h0);
        tick();
        chk("t6_clk3_h", 32'(clock_out[3]), 32'h0);
        tick();
        chk("t6_clk3_i", 32'(clock_out[3]), 32'h1);
        chk("t6_ps3_i", 32'(period_start[3]), 32'h1);

        // Reset while ch2 has a pending update discards it.
        wr(2'd2, 6, 3, 1'b1, 1'b1);
        tick();
        cfg_valid = 1'b0;
        chk("t7_pend_a", 32'(pending), 32'h4);
        reset = 1'b1;
        #1;
        chk("t7_rst_pend", 32'(pending), 32'h0);
        chk("t7_rst_clk", 32'(clock_out), 32'h0);
        chk("t7_rst_ps", 32'(period_start), 32'h0);
        chk("t7_rst_err", 32'(cfg_err), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("t7_clk_a", 32'(clock_out), 32'hF);
        chk("t7_ps_a", 32'(period_start), 32'h0);
        tick();
        chk("t7_clk_b", 32'(clock_out), 32'h0);
        chk("t7_ps_b", 32'(period_start), 32'hF);
        tick();
        chk("t7_clk_c", 32'(clock_out), 32'hF);
        chk("t7_pend_c", 32'(pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
